hack_program_loader: RTL
========================

# hack_program_loader

Byte-stream program loader that sits directly upstream of the Hack computer's RAM and program counter. It receives a framed program image over a valid/ready byte interface, writes each 16-bit word into consecutive RAM locations, loads the PC with the image's start address, then releases the CPU to run. It replaces the hard-wired program preload with a loadable, checkable image.

## Interface
- ADDR_W, 7: RAM address width; RAM depth is 2**ADDR_W words.
- WORD_W, 16: instruction/data word width; fixed at 16 for Hack.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; one clock; sampled on the rising edge of clock.
- in_data  in  8  image byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready at the rising edge.
- ram_load  out  1  one-cycle RAM write strobe.
- ram_address  out  ADDR_W  RAM write address.
- ram_input  out  16  RAM write data.
- pc_load  out  1  one-cycle PC load strobe.
- pc_in  out  16  PC load value (image start address).
- cpu_run  out  1  high when the CPU may execute; low holds it idle.
- error  out  1  sticky framing/range/checksum error.

## Operation
- Image format, all fields big-endian: START (2 bytes), COUNT (2 bytes), COUNT data words (2 bytes each, high byte first), then CHECK byte when checksum is enabled.
- States: IDLE, HDR_S_HI, HDR_S_LO, HDR_C_HI, HDR_C_LO, DATA_HI, DATA_LO, WRITE, CHECK, START, RUN, ERROR.
- IDLE -> HDR_S_HI on the cycle after reset deasserts. Each HDR/DATA/CHECK state consumes exactly one byte and advances.
- After HDR_C_LO: START >= 2**ADDR_W or START+COUNT > 2**ADDR_W -> ERROR (no wrap-around writes). COUNT == 0 -> CHECK (or START if checksum is disabled). Otherwise -> DATA_HI.
- DATA_LO -> WRITE: ram_load=1, ram_address=current pointer, ram_input={hi,lo}. Pointer increments; remaining count decrements. WRITE -> DATA_HI if words remain, else CHECK/START.
- CHECK: the byte must equal the XOR of all data bytes; a mismatch -> ERROR.
- START: pc_load=1, pc_in=START for one cycle -> RUN. RUN: cpu_run=1 held until reset; in_ready=0, extra bytes are ignored.
- ERROR: error=1, cpu_run=0, in_ready=0 until reset. No further RAM writes.

## Timing
- Reset values: in_ready=0, ram_load=0, ram_address=0, ram_input=0, pc_load=0, pc_in=0, cpu_run=0, error=0; state=IDLE.
- in_ready is 1 only in HDR_*, DATA_*, and CHECK, and is a registered function of state. It is 0 in WRITE, so every word costs at least 3 cycles.
- RAM write happens one cycle after the low data byte is accepted. ram_address/ram_input are stable during ram_load.
- pc_load rises the cycle after the last write (or CHECK). cpu_run rises the cycle after pc_load.
- in_valid low stalls any byte state indefinitely, with no timeout.
- Reset mid-load returns to IDLE immediately. Words already written stay in RAM. The next image starts from HDR_S_HI.

## Configuration
- LOADER_CHECKSUM_EN defined: CHECK state present, XOR accumulator built, mismatch asserts error.
- Undefined: no CHECK byte expected. The last WRITE (or COUNT==0) goes straight to START. error is driven only by range faults.

## Structure
- Shared package hack_pkg: loader state enum, WORD_W, default ADDR_W, and the Hack word type.
- One sub-module: loader_byte_pair, which assembles high/low bytes into a 16-bit word and, when enabled, holds the running XOR.
- The top level holds the FSM, address pointer, remaining-count counter, and output registers.

## Test plan
- Image START=64, COUNT=2, words 0x0002, 0xFC10, CHECK=0xEE -> RAM[64]=0x0002, RAM[65]=0xFC10; pc_load with pc_in=64; cpu_run=1; error=0.
- Same image with CHECK=0x00 (checksum enabled) -> no pc_load; error=1; cpu_run=0; in_ready=0.
- START=120, COUNT=10 -> ERROR after the COUNT low byte; zero ram_load pulses.
- START=127, COUNT=1, word 0x1234 -> RAM[127]=0x1234 (last legal address); then RUN.
- START=5, COUNT=0 -> no writes; pc_in=5; cpu_run=1.
- in_valid toggled randomly plus reset asserted after the 3rd data word, then the image reloaded -> IDLE on reset, outputs at reset values, full reload succeeds.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types for the Hack program loader: loader state encoding, word width, default RAM address width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hack_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int HACK_ADDR_W = 7;

    typedef logic [HACK_WORD_W-1:0] hack_word_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_S_HI,
        ST_HDR_S_LO,
        ST_HDR_C_HI,
        ST_HDR_C_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
        ST_CHECK,
        ST_START,
        ST_RUN,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/hack_program_loader_byte_pair.sv
// loader_byte_pair: holds the high byte of a big-endian pair and presents {hi, current byte} as a word.
// Latency: word is combinational on the low byte; hi byte and running XOR update on the accepting edge.
// Backpressure: none; the parent decides when bytes are taken. Running XOR exists only with LOADER_CHECKSUM_EN.
module loader_byte_pair
    import hack_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       take_hi,
    input  logic [7:0] in_data,
`ifdef LOADER_CHECKSUM_EN
    input  logic       take_data,
    output logic [7:0] checksum,
`endif
    output hack_word_t word
);

    logic [7:0] hi_byte;

    // Capture the high byte of the current pair; cleared between images.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            hi_byte <= 8'h00;
        end else if (take_hi) begin
            hi_byte <= in_data;
        end
    end

    assign word = {hi_byte, in_data};

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every data byte (header bytes are excluded).
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            checksum <= 8'h00;
        end else if (take_data) begin
            checksum <= checksum ^ in_data;
        end
    end
`endif

endmodule

// File: rtl/hack_program_loader.sv
// hack_program_loader: parses a big-endian START/COUNT/data image, writes words to Hack RAM, loads PC, releases CPU.
// Latency: RAM write one cycle after each low data byte; pc_load one cycle after last write (or CHECK); cpu_run one cycle later.
// Backpressure: in_ready registered, high only in header/data/check states; LOADER_CHECKSUM_EN adds the trailing XOR CHECK byte.
module hack_program_loader
    import hack_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int WORD_W = HACK_WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] ram_input,
    output logic              pc_load,
    output logic [WORD_W-1:0] pc_in,
    output logic              cpu_run,
    output logic              error
);

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    loader_state_t     state;
    hack_word_t        start_addr;
    hack_word_t        remaining;
    hack_word_t        word;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              take_hi;
    logic              range_bad;
`ifdef LOADER_CHECKSUM_EN
    logic              take_data;
    logic [7:0]        checksum;
`endif

    assign accept  = in_valid && in_ready;
    assign take_hi = accept && (state == ST_HDR_S_HI || state == ST_HDR_C_HI || state == ST_DATA_HI);
`ifdef LOADER_CHECKSUM_EN
    assign take_data = accept && (state == ST_DATA_HI || state == ST_DATA_LO);
`endif

    // Image must fit entirely inside RAM; no wrap-around writes. Only meaningful in HDR_C_LO (word = COUNT).
    assign range_bad = ({1'b0, start_addr} >= DEPTH) ||
                       (({1'b0, start_addr} + {1'b0, word}) > DEPTH);

    loader_byte_pair u_pair (
        .clock     (clock),
        .reset     (reset),
        .clear     (state == ST_IDLE),
        .take_hi   (take_hi),
        .in_data   (in_data),
`ifdef LOADER_CHECKSUM_EN
        .take_data (take_data),
        .checksum  (checksum),
`endif
        .word      (word)
    );

    // Loader FSM with registered outputs; in_ready is set for the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_ready    <= 1'b0;
            ram_load    <= 1'b0;
            ram_address <= '0;
            ram_input   <= '0;
            pc_load     <= 1'b0;
            pc_in       <= '0;
            cpu_run     <= 1'b0;
            error       <= 1'b0;
            start_addr  <= '0;
            remaining   <= '0;
            ptr         <= '0;
        end else begin
            ram_load <= 1'b0;
            pc_load  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state    <= ST_HDR_S_HI;
                    in_ready <= 1'b1;
                end
                ST_HDR_S_HI: if (accept) state <= ST_HDR_S_LO;
                ST_HDR_S_LO: if (accept) begin
                    start_addr <= word;
                    state      <= ST_HDR_C_HI;
                end
                ST_HDR_C_HI: if (accept) state <= ST_HDR_C_LO;
                ST_HDR_C_LO: if (accept) begin
                    remaining <= word;
                    ptr       <= start_addr[ADDR_W-1:0];
                    if (range_bad) begin
                        state    <= ST_ERROR;
                        error    <= 1'b1;
                        in_ready <= 1'b0;
                    end else if (word == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= ST_CHECK;
`else
                        state    <= ST_START;
                        pc_load  <= 1'b1;
                        pc_in    <= start_addr;
                        in_ready <= 1'b0;
`endif
                    end else begin
                        state <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: if (accept) state <= ST_DATA_LO;
                ST_DATA_LO: if (accept) begin
                    ram_load    <= 1'b1;
                    ram_address <= ptr;
                    ram_input   <= word;
                    ptr         <= ptr + 1'b1;
                    remaining   <= remaining - 16'd1;
                    in_ready    <= 1'b0;
                    state       <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (remaining != '0) begin
                        state    <= ST_DATA_HI;
                        in_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= ST_CHECK;
                        in_ready <= 1'b1;
`else
                        state    <= ST_START;
                        pc_load  <= 1'b1;
                        pc_in    <= start_addr;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: if (accept) begin
                    in_ready <= 1'b0;
                    if (in_data == checksum) begin
                        state   <= ST_START;
                        pc_load <= 1'b1;
                        pc_in   <= start_addr;
                    end else begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                    end
                end
`endif
                ST_START: begin
                    state   <= ST_RUN;
                    cpu_run <= 1'b1;
                end
                ST_RUN: begin
                    cpu_run  <= 1'b1;
                    in_ready <= 1'b0;
                end
                ST_ERROR: begin
                    error    <= 1'b1;
                    cpu_run  <= 1'b0;
                    in_ready <= 1'b0;
                end
                default: begin
                    state    <= ST_ERROR;
                    error    <= 1'b1;
                    cpu_run  <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
